// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture/scaler: camera formats, RGB332 fields,
// capture FSM states and small pixel helpers.
package cam_pkg;

    localparam int unsigned CNT_W = 12;

    typedef enum logic [1:0] {
        MODE_RGB565 = 2'd0,
        MODE_RGB444 = 2'd1,
        MODE_YUYV   = 2'd2,
        MODE_RAW    = 2'd3
    } cam_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cam_state_e;

    localparam logic [7:0] RED_VGA   = 8'hE0;
    localparam logic [7:0] GREEN_VGA = 8'h1C;
    localparam logic [7:0] BLUE_VGA  = 8'h03;

    // Fold one camera byte pair into an RGB332 pixel.
    function automatic logic [7:0] to_rgb332(input cam_mode_e m, input logic [7:0] b0,
                                             input logic [7:0] b1);
        logic [7:0] px;
        case (m)
            MODE_RGB565: px = {b0[7:5], b0[2:0], b1[4:3]};
            MODE_RGB444: px = {b0[3:1], b1[7:5], b1[3:2]};
            MODE_YUYV:   px = {b0[7:5], b0[7:5], b0[7:6]};
            default:     px = b0;
        endcase
        return px & (RED_VGA | GREEN_VGA | BLUE_VGA);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/cam_capture_scaler_if.sv
// Frame-buffer RAM write port driven by the capture block.
interface cam_capture_scaler_if #(
    parameter int unsigned AW = 15,
    parameter int unsigned DW = 8
);
    logic [AW-1:0] DP_RAM_addr_in;
    logic [DW-1:0] DP_RAM_data_in;
    logic          DP_RAM_regW;

    modport master (output DP_RAM_addr_in, output DP_RAM_data_in, output DP_RAM_regW);
    modport slave  (input  DP_RAM_addr_in, input  DP_RAM_data_in, input  DP_RAM_regW);
endinterface

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser for an asynchronous camera line, plus an edge-detect stage.
module cam_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_c,
    output logic fall_c
);
    logic [2:0] sh_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sh_q <= '0;
        else      sh_q <= {sh_q[1:0], d_i};
    end

    assign lvl_o  = sh_q[1];
    assign rise_c = sh_q[1] & ~sh_q[2];
    assign fall_c = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/cam_capture_scaler.sv
// OV7670 capture: oversampled camera bus, byte pairing, RGB332 conversion,
// power-of-two decimation and linear frame-buffer writes with capture control.
module cam_capture_scaler
    import cam_pkg::*;
#(
    parameter int unsigned CAM_SCREEN_X = 160,
    parameter int unsigned CAM_SCREEN_Y = 120,
    parameter int unsigned AW           = 15,
    parameter int unsigned DW           = 8,
    parameter int unsigned DEC_LOG2     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Pclk,
    input  logic       Href,
    input  logic       Vsync,
    input  logic [7:0] Datos,
    input  logic [1:0] mode,
    input  logic       cap_en,
    input  logic       single,
    cam_capture_scaler_if.master ram,
    output logic       frame_done,
    output logic       busy,
    output logic       line_err
);
    localparam logic [CNT_W-1:0] DEC_MASK = CNT_W'((32'd1 << DEC_LOG2) - 32'd1);

    logic pclk_lvl, pclk_rise, pclk_fall;
    logic href_lvl, href_rise, href_fall;
    logic vs_lvl, vs_rise, vs_fall;
    logic sync_unused;
    logic [7:0] dat_s1_q, dat_s2_q;

    cam_state_e       state_q, state_d;
    cam_mode_e        mode_q;
    logic             phase_q, hold_q;
    logic [7:0]       b0_q;
    logic [CNT_W-1:0] cam_col_q, cam_row_q;
    logic [CNT_W-1:0] col_w, row_w;
    logic             keep_c;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    data_q;
    logic             regw_q, frame_done_q, busy_q, line_err_q;

    cam_sync_edge u_pclk  (.clk(clk), .rst(rst), .d_i(Pclk),  .lvl_o(pclk_lvl), .rise_c(pclk_rise), .fall_c(pclk_fall));
    cam_sync_edge u_href  (.clk(clk), .rst(rst), .d_i(Href),  .lvl_o(href_lvl), .rise_c(href_rise), .fall_c(href_fall));
    cam_sync_edge u_vsync (.clk(clk), .rst(rst), .d_i(Vsync), .lvl_o(vs_lvl),   .rise_c(vs_rise),   .fall_c(vs_fall));

    assign sync_unused = &{pclk_lvl, pclk_fall, href_rise, vs_lvl};

    // Data bus shares the Pclk synchroniser depth so the byte lines up with its strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dat_s1_q <= '0;
            dat_s2_q <= '0;
        end else begin
            dat_s1_q <= Datos;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Decimated position, keep/clip decision and the linear write address.
    always_comb begin
        col_w  = cam_col_q >> DEC_LOG2;
        row_w  = cam_row_q >> DEC_LOG2;
        keep_c = ((cam_col_q & DEC_MASK) == '0) && ((cam_row_q & DEC_MASK) == '0)
                 && (col_w < CNT_W'(CAM_SCREEN_X)) && (row_w < CNT_W'(CAM_SCREEN_Y));
        addr_d = AW'(row_w) * AW'(CAM_SCREEN_X) + AW'(col_w);
    end

    // A finished single shot holds in IDLE until cap_en is dropped and raised again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cap_en && !hold_q) state_d = ST_ARM;
            ST_ARM:     if (!cap_en) state_d = ST_IDLE;
                        else if (vs_fall) state_d = ST_CAPTURE;
            ST_CAPTURE: if (vs_rise) state_d = ST_DONE;
            ST_DONE:    state_d = (cap_en && !single) ? ST_ARM : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_RGB565;
            phase_q      <= 1'b0;
            hold_q       <= 1'b0;
            b0_q         <= '0;
            cam_col_q    <= '0;
            cam_row_q    <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            regw_q       <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            regw_q       <= 1'b0;
            frame_done_q <= (state_d == ST_DONE);
            busy_q       <= (state_d == ST_ARM) || (state_d == ST_CAPTURE);

            if (!cap_en)                  hold_q <= 1'b0;
            else if (state_q == ST_DONE)  hold_q <= 1'b1;

            if (state_d == ST_ARM && state_q != ST_ARM) begin
                mode_q     <= cam_mode_e'(mode);
                line_err_q <= 1'b0;
            end

            if (state_q == ST_ARM && state_d == ST_CAPTURE) begin
                cam_col_q <= '0;
                cam_row_q <= '0;
                phase_q   <= 1'b0;
            end else if (state_q == ST_CAPTURE) begin
                if (vs_rise) begin
                    phase_q <= 1'b0;
                end else if (href_fall) begin
                    cam_col_q <= '0;
                    cam_row_q <= sat_inc(cam_row_q);
                    if (phase_q) line_err_q <= 1'b1;
                    phase_q   <= 1'b0;
                end else if (pclk_rise && href_lvl) begin
                    if (!phase_q) begin
                        b0_q    <= dat_s2_q;
                        phase_q <= 1'b1;
                    end else begin
                        phase_q   <= 1'b0;
                        cam_col_q <= sat_inc(cam_col_q);
                        if (keep_c) begin
                            regw_q <= 1'b1;
                            addr_q <= addr_d;
                            data_q <= DW'(to_rgb332(mode_q, b0_q, dat_s2_q));
                        end
                    end
                end
            end
        end
    end

    assign ram.DP_RAM_addr_in = addr_q;
    assign ram.DP_RAM_data_in = data_q;
    assign ram.DP_RAM_regW    = regw_q;
    assign frame_done         = frame_done_q;
    assign busy               = busy_q;
    assign line_err           = line_err_q;
endmodule

// File: tb/tb_cam_capture_scaler.sv
// Scoreboard bench for cam_capture_scaler on a reduced 8x6 buffer with 2x decimation.
module tb_cam_capture_scaler;
    import cam_pkg::*;

    localparam int unsigned SX  = 8;
    localparam int unsigned SY  = 6;
    localparam int unsigned AW  = 6;
    localparam int unsigned DW  = 8;
    localparam int unsigned DEC = 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic       clk;
    logic       rst, Pclk, Href, Vsync, cap_en, single;
    logic [7:0] Datos;
    logic [1:0] mode;
    logic       frame_done, busy, line_err;

    cam_capture_scaler_if #(.AW(AW), .DW(DW)) ram ();

    cam_capture_scaler #(
        .CAM_SCREEN_X(SX), .CAM_SCREEN_Y(SY), .AW(AW), .DW(DW), .DEC_LOG2(DEC)
    ) dut (
        .clk(clk), .rst(rst), .Pclk(Pclk), .Href(Href), .Vsync(Vsync), .Datos(Datos),
        .mode(mode), .cap_en(cap_en), .single(single), .ram(ram),
        .frame_done(frame_done), .busy(busy), .line_err(line_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         errors = 0, checks = 0, fd_seen = 0, fd_exp = 0;
    logic [7:0] b0_g, b1_g, exp_data;
    bit         exp_on = 0, cap_val = 0;
    logic [1:0] cap_mode = 2'd0;
    int         cap_row = -1, rst_row = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (ram.DP_RAM_regW === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, no write expected (t=%0t)",
                             ram.DP_RAM_addr_in, ram.DP_RAM_data_in, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 32'(ram.DP_RAM_addr_in), 32'(mon_e.addr));
                    chk("wr_data", 32'(ram.DP_RAM_data_in), 32'(mon_e.data));
                end
            end
            if (frame_done === 1'b1) fd_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        Datos = b;
        tick(2);
        Pclk = 1'b1;
        tick(2);
        Pclk = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        tick(1);
        chk("rst_regW",     32'(ram.DP_RAM_regW),    32'd0);
        chk("rst_addr",     32'(ram.DP_RAM_addr_in), 32'd0);
        chk("rst_data",     32'(ram.DP_RAM_data_in), 32'd0);
        chk("rst_done",     32'(frame_done),         32'd0);
        chk("rst_busy",     32'(busy),               32'd0);
        chk("rst_line_err", 32'(line_err),           32'd0);
        tick(1);
        rst    = 1'b1;
        exp_on = 0;
    endtask

    task automatic send_line(input int r, input int ncols, input bit odd);
        wr_t w;
        Href = 1'b1;
        for (int c = 0; c < ncols; c++) begin
            if (r == rst_row && c == 5) pulse_reset();
            if (exp_on && (c % 2 == 0) && (r % 2 == 0) && (c / 2 < SX) && (r / 2 < SY)) begin
                w.addr = AW'((r / 2) * SX + c / 2);
                w.data = exp_data;
                exp_q.push_back(w);
            end
            send_byte(b0_g);
            send_byte(b1_g);
        end
        if (odd) send_byte(b0_g);
        tick(2);
        Href = 1'b0;
        tick(8);
    endtask

    // 16x12 camera frame; the first line may be longer and/or end on an odd byte.
    task automatic send_frame(input int first_cols, input bit first_odd);
        Vsync = 1'b0;
        tick(8);
        for (int r = 0; r < 12; r++) begin
            if (r == cap_row) begin
                cap_en = cap_val;
                mode   = cap_mode;
                tick(4);
                chk("busy_mid_frame", 32'(busy), 32'd1);
            end
            send_line(r, (r == 0) ? first_cols : 16, (r == 0) ? first_odd : 1'b0);
        end
        Vsync = 1'b1;
        if (exp_on) fd_exp++;
        tick(24);
        cap_row = -1;
        rst_row = -1;
    endtask

    task automatic end_chk(input logic busy_req, input logic lerr_req);
        tick(8);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        chk("frame_done_cycles", 32'(fd_seen), 32'(fd_exp));
        chk("busy_end", 32'(busy), 32'(busy_req));
        chk("line_err_end", 32'(line_err), 32'(lerr_req));
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b0; Pclk = 1'b0; Href = 1'b0; Vsync = 1'b1; Datos = 8'h00;
        mode = 2'd0; cap_en = 1'b0; single = 1'b0;
        tick(3);
        chk("reset_regW",     32'(ram.DP_RAM_regW),    32'd0);
        chk("reset_addr",     32'(ram.DP_RAM_addr_in), 32'd0);
        chk("reset_data",     32'(ram.DP_RAM_data_in), 32'd0);
        chk("reset_done",     32'(frame_done),         32'd0);
        chk("reset_busy",     32'(busy),               32'd0);
        chk("reset_line_err", 32'(line_err),           32'd0);
        rst = 1'b1;
        tick(4);
        chk("idle_busy", 32'(busy), 32'd0);

        // RGB565 pure red, single shot
        mode = 2'd0; single = 1'b1; cap_en = 1'b1;
        tick(4);
        chk("arm_busy", 32'(busy), 32'd1);
        b0_g = 8'hF8; b1_g = 8'h00; exp_data = 8'hE0; exp_on = 1;
        send_frame(16, 1'b0);
        end_chk(1'b0, 1'b0);

        // RGB444 continuous; cap_en dropped and mode changed mid second frame
        cap_en = 1'b0; tick(4);
        mode = 2'd1; single = 1'b0; cap_en = 1'b1; tick(4);
        b0_g = 8'h0F; b1_g = 8'hF0; exp_data = 8'hFC; exp_on = 1;
        send_frame(16, 1'b0);
        cap_row = 5; cap_val = 1'b0; cap_mode = 2'd3;
        send_frame(16, 1'b0);
        end_chk(1'b0, 1'b0);

        // YUYV grey single shot, second frame must be ignored
        mode = 2'd2; single = 1'b1; cap_en = 1'b1; tick(4);
        b0_g = 8'h80; b1_g = 8'h55; exp_data = 8'h92; exp_on = 1;
        send_frame(16, 1'b0);
        exp_on = 0;
        send_frame(16, 1'b0);
        end_chk(1'b0, 1'b0);

        // Raw byte0 with an over-long first line ending on an odd byte
        cap_en = 1'b0; tick(4);
        mode = 2'd3; cap_en = 1'b1; tick(4);
        b0_g = 8'h5A; b1_g = 8'h33; exp_data = 8'h5A; exp_on = 1;
        send_frame(21, 1'b1);
        end_chk(1'b0, 1'b1);

        // Reset mid-line; capture resumes only at the next frame
        cap_en = 1'b0; tick(4);
        mode = 2'd0; cap_en = 1'b1; tick(4);
        b0_g = 8'hF8; b1_g = 8'h00; exp_data = 8'hE0; exp_on = 1;
        rst_row = 1;
        send_frame(16, 1'b0);
        exp_on = 1;
        send_frame(16, 1'b0);
        end_chk(1'b0, 1'b0);

        // cap_en raised mid-frame; first write comes from the following frame
        cap_en = 1'b0; tick(4);
        exp_on = 0; cap_row = 4; cap_val = 1'b1; cap_mode = 2'd0;
        send_frame(16, 1'b0);
        exp_on = 1;
        send_frame(16, 1'b0);
        end_chk(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
